irq_controller: RTL and testbench

Memory-mapped interrupt controller that drives the pipelined CPU's `IRQ` input. It sits on the MEM-stage data bus beside `DataMemory`. It latches rising edges on external interrupt lines into a pending register and applies a mask. It raises `IRQ` to the CPU and holds it until the CPU acknowledges exception entry, then blocks further requests until software writes EOI. An optional built-in timer can be compiled in as source 0.

---
 rtl/irq_pkg.sv | 23 ++
 rtl/irq_prio_enc.sv | 22 ++
 rtl/irq_controller.sv | 226 ++++++++++++++++++++++
 tb/tb_irq_controller.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register window offsets,
// the request/service state encoding and the CAUSE valid bit position.
package irq_pkg;

    // Byte offsets of the registers inside the 8-word window
    localparam logic [4:0] IRQ_OFS_PEND  = 5'h00;
    localparam logic [4:0] IRQ_OFS_MASK  = 5'h04;
    localparam logic [4:0] IRQ_OFS_CAUSE = 5'h08;
    localparam logic [4:0] IRQ_OFS_EOI   = 5'h0C;
    localparam logic [4:0] IRQ_OFS_GCTL  = 5'h10;
    localparam logic [4:0] IRQ_OFS_TH    = 5'h14;
    localparam logic [4:0] IRQ_OFS_TL    = 5'h18;
    localparam logic [4:0] IRQ_OFS_TCON  = 5'h1C;

    localparam int CAUSE_VALID_BIT = 31;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder over the active interrupt vector.
// any_o reports whether any bit is set; id_o is 0 when nothing is set.
module irq_prio_enc #(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0] vec_i,
    output logic             any_o,
    output logic [4:0]       id_o
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        any_o = |vec_i;
        id_o  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                id_o = 5'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller driving the CPU IRQ line.
// Rising edges on src latch into PEND; PEND & MASK with GCTL enable raises irq,
// which holds until the CPU acks exception entry; the controller then waits
// for an EOI write before it will request again.
// Optional feature: define IRQ_TIMER_EN to build a 32-bit auto-reload timer
// that replaces src[0] as interrupt source 0.
module irq_controller
    import irq_pkg::*;
#(
    parameter int          N_SRC     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0020
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    input  logic [31:0]      Address,
    input  logic [31:0]      Write_data,
    input  logic             MemRead,
    input  logic             MemWrite,
    output logic [31:0]      Read_data,
    output logic             hit,
    output logic             irq,
    input  logic             irq_ack
);

    logic [N_SRC-1:0] srcPrev_q;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic             gctl_q, gctl_d;
    logic             causeValid_q, causeValid_d;
    logic [4:0]       causeId_q, causeId_d;
    irq_state_e       state_q, state_d;
    logic             irq_q, irq_d;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] active;
    logic [N_SRC-1:0] ackClr;
    logic [N_SRC-1:0] w1cClr;
    logic             req;
    logic             encAny;
    logic [4:0]       encId;
    logic [4:0]       regOfs;
    logic             wrEn;
    logic             wrPend, wrMask, wrEoi, wrGctl;
    logic             timerPulse;

    // MemRead only qualifies reads for debug; byte lanes are never used
    logic unused_inputs;
    assign unused_inputs = ^{MemRead, Address[1:0], Write_data};

    assign hit    = (Address[31:5] == BASE_ADDR[31:5]);
    assign regOfs = {Address[4:2], 2'b00};
    assign wrEn   = MemWrite & hit;
    assign wrPend = wrEn && (regOfs == IRQ_OFS_PEND);
    assign wrMask = wrEn && (regOfs == IRQ_OFS_MASK);
    assign wrEoi  = wrEn && (regOfs == IRQ_OFS_EOI);
    assign wrGctl = wrEn && (regOfs == IRQ_OFS_GCTL);

    assign active = pend_q & mask_q;
    assign req    = gctl_q & (|active);
    assign irq    = irq_q;

    irq_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio_enc (
        .vec_i (active),
        .any_o (encAny),
        .id_o  (encId)
    );

`ifdef IRQ_TIMER_EN
    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic        run_q, run_d;
    logic        wrTh, wrTl, wrTcon;

    assign wrTh       = wrEn && (regOfs == IRQ_OFS_TH);
    assign wrTl       = wrEn && (regOfs == IRQ_OFS_TL);
    assign wrTcon     = wrEn && (regOfs == IRQ_OFS_TCON);
    assign timerPulse = run_q && (tl_q == 32'hFFFF_FFFF);

    // Timer next state: count while running, reload from TH on wrap; software TL write wins
    always_comb begin
        th_d  = th_q;
        tl_d  = tl_q;
        run_d = run_q;
        if (run_q) begin
            tl_d = timerPulse ? th_q : tl_q + 32'd1;
        end
        if (wrTh) begin
            th_d = Write_data;
        end
        if (wrTl) begin
            tl_d = Write_data;
        end
        if (wrTcon) begin
            run_d = Write_data[0];
        end
    end

    // Timer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            th_q  <= '0;
            tl_q  <= '0;
            run_q <= 1'b0;
        end else begin
            th_q  <= th_d;
            tl_q  <= tl_d;
            run_q <= run_d;
        end
    end

    // Source 0 comes from the timer wrap pulse instead of the external line
    always_comb begin
        rise    = src & ~srcPrev_q;
        rise[0] = timerPulse;
    end
`else
    assign timerPulse = 1'b0;

    // Edge detect on every external line
    always_comb begin
        rise = src & ~srcPrev_q;
    end
`endif

    // Request/service FSM plus PEND/MASK/GCTL/CAUSE next state
    always_comb begin
        state_d      = state_q;
        causeValid_d = causeValid_q;
        causeId_d    = causeId_q;
        mask_d       = mask_q;
        gctl_d       = gctl_q;
        ackClr       = '0;
        w1cClr       = '0;

        if (wrMask) begin
            mask_d = Write_data[N_SRC-1:0];
        end
        if (wrGctl) begin
            gctl_d = Write_data[0];
        end
        if (wrPend) begin
            w1cClr = Write_data[N_SRC-1:0];
        end

        case (state_q)
            IRQ_IDLE: begin
                if (req) begin
                    state_d = IRQ_REQ;
                end
            end
            IRQ_REQ: begin
                if (irq_ack) begin
                    state_d      = IRQ_SERVICE;
                    causeValid_d = encAny;
                    causeId_d    = encAny ? encId : 5'd0;
                    if (encAny) begin
                        ackClr = N_SRC'(1) << encId;
                    end
                end else if (!req) begin
                    state_d = IRQ_IDLE;
                end
            end
            IRQ_SERVICE: begin
                if (wrEoi) begin
                    causeValid_d = 1'b0;
                    state_d      = IRQ_IDLE;
                end
            end
            default: begin
                state_d = IRQ_IDLE;
            end
        endcase

        pend_d = (pend_q & ~ackClr & ~w1cClr) | rise;
        irq_d  = (state_d == IRQ_REQ);
    end

    // Controller state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            srcPrev_q    <= '0;
            pend_q       <= '0;
            mask_q       <= '0;
            gctl_q       <= 1'b0;
            causeValid_q <= 1'b0;
            causeId_q    <= '0;
            state_q      <= IRQ_IDLE;
            irq_q        <= 1'b0;
        end else begin
            srcPrev_q    <= src;
            pend_q       <= pend_d;
            mask_q       <= mask_d;
            gctl_q       <= gctl_d;
            causeValid_q <= causeValid_d;
            causeId_q    <= causeId_d;
            state_q      <= state_d;
            irq_q        <= irq_d;
        end
    end

    // Combinational register read mux; zero outside the window
    always_comb begin
        Read_data = '0;
        if (hit) begin
            case (regOfs)
                IRQ_OFS_PEND:  Read_data[N_SRC-1:0] = pend_q;
                IRQ_OFS_MASK:  Read_data[N_SRC-1:0] = mask_q;
                IRQ_OFS_CAUSE: begin
                    Read_data[CAUSE_VALID_BIT] = causeValid_q;
                    Read_data[4:0]             = causeId_q;
                end
                IRQ_OFS_GCTL:  Read_data[0] = gctl_q;
`ifdef IRQ_TIMER_EN
                IRQ_OFS_TH:    Read_data = th_q;
                IRQ_OFS_TL:    Read_data = tl_q;
                IRQ_OFS_TCON:  Read_data[0] = run_q;
`endif
                default:       Read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
// Define IRQ_TIMER_EN to also exercise the built-in timer.
module tb_irq_controller;

    localparam int          N    = 8;
    localparam logic [31:0] BASE = 32'h4000_0020;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  src;
    logic [31:0]   Address;
    logic [31:0]   Write_data;
    logic          MemRead;
    logic          MemWrite;
    logic [31:0]   Read_data;
    logic          hit;
    logic          irq;
    logic          irq_ack;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [N-1:0] mPend, mMask, mPrev;
    logic         mGctl, mIrq, mSvc, mRun;
    logic [31:0]  mCause, mTh, mTl;

    logic [N-1:0] curSrc;
    logic [31:0]  rd;

    always #10 clk = ~clk;

    irq_controller #(
        .N_SRC     (N),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .src        (src),
        .Address    (Address),
        .Write_data (Write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Read_data  (Read_data),
        .hit        (hit),
        .irq        (irq),
        .irq_ack    (irq_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lowestSet(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] expRead(input logic [4:0] ofs);
        case (ofs)
            5'h00:   return 32'(mPend);
            5'h04:   return 32'(mMask);
            5'h08:   return mCause;
            5'h10:   return 32'(mGctl);
`ifdef IRQ_TIMER_EN
            5'h14:   return mTh;
            5'h18:   return mTl;
            5'h1C:   return 32'(mRun);
`endif
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently driven
    task automatic modelStep();
        logic [N-1:0] rise, act, np;
        logic         req, wr, pulse, nIrq, nSvc;
        logic [31:0]  nCause;
        logic [4:0]   ofs;
        int           id;
        if (reset) begin
            mPend = '0; mMask = '0; mPrev = '0; mGctl = 0; mIrq = 0; mSvc = 0;
            mCause = '0; mTh = '0; mTl = '0; mRun = 0;
            return;
        end
        wr    = MemWrite && (Address[31:5] == BASE[31:5]);
        ofs   = {Address[4:2], 2'b00};
        rise  = src & ~mPrev;
        pulse = 1'b0;
`ifdef IRQ_TIMER_EN
        pulse   = mRun && (mTl == 32'hFFFF_FFFF);
        rise[0] = pulse;
`endif
        act    = mPend & mMask;
        req    = mGctl && (act != 0);
        np     = mPend;
        nIrq   = mIrq;
        nSvc   = mSvc;
        nCause = mCause;
        if (wr && ofs == 5'h00) np = np & ~Write_data[N-1:0];
        if (mIrq) begin
            if (irq_ack) begin
                id = lowestSet(act);
                if (id >= 0) begin
                    np[id] = 1'b0;
                    nCause = 32'h8000_0000 | 32'(id);
                end else begin
                    nCause = 32'h0;
                end
                nIrq = 0;
                nSvc = 1;
            end else if (!req) begin
                nIrq = 0;
            end
        end else if (mSvc) begin
            if (wr && ofs == 5'h0C) begin
                nCause[31] = 1'b0;
                nSvc = 0;
            end
        end else if (req) begin
            nIrq = 1;
        end
        np = np | rise;
        if (wr && ofs == 5'h04) mMask = Write_data[N-1:0];
        if (wr && ofs == 5'h10) mGctl = Write_data[0];
`ifdef IRQ_TIMER_EN
        if (mRun) mTl = pulse ? mTh : mTl + 32'd1;
        if (wr && ofs == 5'h14) mTh = Write_data;
        if (wr && ofs == 5'h18) mTl = Write_data;
        if (wr && ofs == 5'h1C) mRun = Write_data[0];
`endif
        mPend  = np;
        mIrq   = nIrq;
        mSvc   = nSvc;
        mCause = nCause;
        mPrev  = src;
    endtask

    task automatic applyStimulus(input logic rst, input logic [N-1:0] s, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wd, input logic ack);
        reset      = rst;
        src        = s;
        MemWrite   = we;
        MemRead    = 1'b0;
        Address    = addr;
        Write_data = wd;
        irq_ack    = ack;
        @(posedge clk);
        modelStep();
        #1;
        irq_ack  = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic readReg(input logic [4:0] ofs, output logic [31:0] v);
        Address  = BASE + 32'(ofs);
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        #1;
        v = Read_data;
    endtask

    task automatic checkOutput(input string tag);
        logic [31:0] v;
        logic [4:0]  ofsList [6] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h18};
        check($sformatf("%s_irq", tag), 32'(irq), 32'(mIrq));
        foreach (ofsList[k]) begin
            readReg(ofsList[k], v);
            check($sformatf("%s_rd%0h", tag, ofsList[k]), v, expRead(ofsList[k]));
        end
        check($sformatf("%s_hit", tag), 32'(hit), 32'd1);
        Address = BASE + 32'h20;
        #1;
        check($sformatf("%s_miss_rd", tag), Read_data, 32'h0);
        check($sformatf("%s_miss_hit", tag), 32'(hit), 32'd0);
    endtask

    initial begin
        reset = 1'b1; src = '0; Address = '0; Write_data = '0;
        MemRead = 1'b0; MemWrite = 1'b0; irq_ack = 1'b0;
        curSrc = '0;

        // Reset state
        applyStimulus(1, 0, 0, BASE, 0, 0);
        applyStimulus(1, 0, 0, BASE, 0, 0);
        checkOutput("reset");

        // Single source 2 through request, ack and EOI
        applyStimulus(0, 0, 1, BASE + 32'h04, 32'h05, 0);
        applyStimulus(0, 0, 1, BASE + 32'h10, 32'h01, 0);
        applyStimulus(0, 8'h04, 0, BASE, 0, 0);
        checkOutput("src2_set");
        readReg(5'h00, rd); check("src2_pend", rd, 32'h04);
        check("src2_irq_low", 32'(irq), 32'd0);
        applyStimulus(0, 0, 0, BASE, 0, 0);
        checkOutput("src2_req");
        check("src2_irq_high", 32'(irq), 32'd1);
        applyStimulus(0, 0, 0, BASE, 0, 1);
        checkOutput("src2_ack");
        readReg(5'h08, rd); check("src2_cause", rd, 32'h8000_0002);
        readReg(5'h00, rd); check("src2_pend_clr", rd, 32'h0);
        applyStimulus(0, 0, 1, BASE + 32'h0C, 32'h0, 0);
        checkOutput("src2_eoi");

        // Two pending sources served lowest first
        applyStimulus(0, 0, 1, BASE + 32'h04, 32'hFF, 0);
        applyStimulus(0, 8'h0A, 0, BASE, 0, 0);
        applyStimulus(0, 0, 0, BASE, 0, 0);
        checkOutput("two_req");
        applyStimulus(0, 0, 0, BASE, 0, 1);
        checkOutput("two_ack1");
        readReg(5'h08, rd); check("two_cause1", rd, 32'h8000_0001);
        readReg(5'h00, rd); check("two_pend1", rd, 32'h08);
        applyStimulus(0, 0, 1, BASE + 32'h0C, 32'h1234, 0);
        checkOutput("two_eoi");
        applyStimulus(0, 0, 0, BASE, 0, 0);
        checkOutput("two_rereq");
        check("two_reraise", 32'(irq), 32'd1);
        applyStimulus(0, 0, 0, BASE, 0, 1);
        checkOutput("two_ack2");
        readReg(5'h08, rd); check("two_cause2", rd, 32'h8000_0003);
        applyStimulus(0, 0, 1, BASE + 32'h0C, 32'h0, 0);

        // Masking while requesting drops irq one cycle later, PEND kept
        applyStimulus(0, 8'h10, 0, BASE, 0, 0);
        applyStimulus(0, 0, 0, BASE, 0, 0);
        applyStimulus(0, 0, 1, BASE + 32'h04, 32'h0, 0);
        checkOutput("mask_req");
        check("mask_irq_still", 32'(irq), 32'd1);
        applyStimulus(0, 0, 0, BASE, 0, 0);
        checkOutput("mask_drop");
        check("mask_irq_low", 32'(irq), 32'd0);
        readReg(5'h00, rd); check("mask_pend_kept", rd, 32'h10);
        applyStimulus(0, 0, 1, BASE + 32'h00, 32'h10, 0);

        // Rising edge beats a W1C clear of the same bit
        applyStimulus(0, 8'h20, 1, BASE + 32'h00, 32'h20, 0);
        checkOutput("setwin");
        readReg(5'h00, rd); check("setwin_pend", rd, 32'h20);
        applyStimulus(0, 0, 0, BASE, 0, 0);

        // Reset during service; a later ack is ignored
        applyStimulus(0, 0, 1, BASE + 32'h04, 32'h20, 0);
        applyStimulus(0, 0, 0, BASE, 0, 0);
        applyStimulus(0, 0, 0, BASE, 0, 1);
        checkOutput("svc");
        readReg(5'h08, rd); check("svc_cause", rd, 32'h8000_0005);
        applyStimulus(1, 0, 0, BASE, 0, 0);
        checkOutput("svc_reset");
        readReg(5'h08, rd); check("svc_reset_cause", rd, 32'h0);
        readReg(5'h04, rd); check("svc_reset_mask", rd, 32'h0);
        applyStimulus(0, 0, 0, BASE, 0, 1);
        checkOutput("post_reset_ack");
        check("post_reset_irq", 32'(irq), 32'd0);

`ifdef IRQ_TIMER_EN
        // Timer reload period of four cycles
        applyStimulus(0, 0, 1, BASE + 32'h14, 32'hFFFF_FFFC, 0);
        applyStimulus(0, 0, 1, BASE + 32'h18, 32'hFFFF_FFFC, 0);
        applyStimulus(0, 0, 1, BASE + 32'h04, 32'h01, 0);
        applyStimulus(0, 0, 1, BASE + 32'h10, 32'h01, 0);
        applyStimulus(0, 0, 1, BASE + 32'h1C, 32'h01, 0);
        for (int c = 0; c < 4; c++) applyStimulus(0, 0, 0, BASE, 0, 0);
        checkOutput("tmr_wrap");
        readReg(5'h18, rd); check("tmr_reload", rd, 32'hFFFF_FFFC);
        readReg(5'h00, rd); check("tmr_pend", rd & 32'h1, 32'h1);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(0, 0, 0, BASE, 0, (c == 3));
            checkOutput("tmr_run");
        end
`endif

        // Randomized traffic
        for (int c = 0; c < 300; c++) begin
            logic [31:0] addr, wd;
            logic        we, ack, rst;
            int          op;
            curSrc = curSrc ^ (N'($urandom) & N'($urandom) & N'($urandom));
            op   = $urandom_range(0, 9);
            we   = 1'b1;
            addr = BASE;
            wd   = $urandom;
            case (op)
                0, 1, 2: we = 1'b0;
                3:       addr = BASE;
                4:       addr = BASE + 32'h04;
                5: begin
                    addr = BASE + 32'h10;
                    wd   = {31'b0, ($urandom_range(0, 3) != 0)};
                end
                6:       addr = BASE + 32'h0C;
                7: begin
                    addr = BASE + 32'h14 + 32'h4 * $urandom_range(0, 2);
                    wd   = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                end
                8:       addr = BASE + 32'h20;
                default: addr = BASE + 32'h08;
            endcase
            ack = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 99) == 0);
            applyStimulus(rst, curSrc, we, addr, wd, ack);
            checkOutput("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
